// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, single slave.
// Define SPI_MASTER_LOOPBACK_EN to make the receiver sample mosi_o instead of miso_i.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  start_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i
);
  localparam int W  = DATA_WIDTH;
  localparam int D  = CLK_DIV;
  localparam int PW = $clog2(D + 1);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  if (D < 1) begin : g_bad_div
    $error("spi_master: CLK_DIV must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0]  tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, rx_next;
  logic          busy_q, busy_d, done_q, done_d, start_q, start_d;
  logic          sclk_q, sclk_d, mosi_q, mosi_d;
  logic          last, sample, accept;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample = mosi_q;
`else
  assign sample = miso_i;
`endif

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_d   = start_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    last      = phase_q == PW'(D - 1);
    phase_d   = (state_q == IDLE || last) ? '0 : phase_q + 1'b1;
    rx_next   = (rx_sh_q << 1) | W'(sample);
    // the last GAP cycle doubles as an accept slot so held start_i gives a D-cycle gap
    accept    = start_i && (state_q == IDLE || (state_q == GAP && last));
    case (state_q)
      SETUP: if (last) begin
        state_d = HI;
        sclk_d  = 1'b1;
      end
      HI: if (last) begin
        rx_sh_d = rx_next;
        sclk_d  = 1'b0;
        if (bit_q == '0) begin
          state_d   = GAP;
          start_d   = 1'b0;
          mosi_d    = 1'b0;
          rx_data_d = rx_next;
          done_d    = 1'b1;
        end else begin
          state_d = LO;
          tx_d    = tx_q << 1;
          mosi_d  = tx_d[W-1];
          bit_d   = bit_q - 1'b1;
        end
      end
      LO: if (last) begin
        state_d = HI;
        sclk_d  = 1'b1;
      end
      GAP: if (last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
    if (accept) begin
      state_d = SETUP;
      tx_d    = tx_data_i;
      busy_d  = 1'b1;
      start_d = 1'b1;
      mosi_d  = tx_data_i[W-1];
      bit_d   = BW'(W - 1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign start_o   = start_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with an 8-bit echo-plus-one slave model.
module tb_spi_master;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, lb = 1'b0;
  logic [7:0] tx = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, start_o, sclk, mosi, miso;
  int         ntests = 0, nfail = 0, cyc = 0, e0 = 0, dcnt = 0, dt, n, d0;

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx),
    .rx_data_o(rx_data), .busy_o(busy), .done_o(done),
    .start_o(start_o), .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso)
  );

  // slave: answers each frame with (previous received frame + 1), shifts after sclk falls
  logic [7:0] s_last, s_sh, s_rx;
  int         s_rises;
  logic       p_start, p_sclk, p_mosi;
  bit         mosi_err = 1'b0;
  assign miso = lb ? 1'b1 : s_sh[7];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_last <= 8'h00; s_sh <= 8'h00; s_rx <= 8'h00; s_rises <= 0;
      p_start <= 1'b0; p_sclk <= 1'b0; p_mosi <= 1'b0;
    end else begin
      p_start <= start_o; p_sclk <= sclk; p_mosi <= mosi;
      if (start_o && !p_start) begin
        s_sh <= s_last + 8'h01;
        s_rises <= 0;
      end else if (!start_o && p_start) s_last <= s_rx;
      if (sclk && !p_sclk) begin
        s_rx <= {s_rx[6:0], mosi};
        s_rises <= s_rises + 1;
      end
      if (!sclk && p_sclk) s_sh <= s_sh << 1;
      if (sclk && p_sclk && mosi != p_mosi) mosi_err <= 1'b1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) dcnt <= dcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx = d;
    start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        t = cyc - e0;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        t = cyc - e0;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rx_data, busy, done, start_o, sclk, mosi}, 0);
    rst = 1'b0;
    // 1: first frame, slave answers 0x01
    @(negedge clk);
    tx = 8'hA5;
    start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    chk("accept_pins", {busy, start_o, sclk, mosi}, 4'b1101);
    @(negedge clk);
    start = 1'b0;
    wait_done(dt);
    chk("t1_done_time", dt, 64);
    chk("t1_rx", rx_data, 8'h01);
    chk("t1_gap_pins", {start_o, sclk, mosi}, 3'b000);
    wait_idle(dt);
    chk("t1_busy_width", dt, 68);
    chk("t1_slave_rx", s_last, 8'hA5);
    chk("t1_sclk_rises", s_rises, 8);
    // 2
    send(8'h3C);
    wait_done(dt);
    chk("t2_rx_a", rx_data, 8'hA6);
    wait_idle(dt);
    send(8'hFF);
    wait_done(dt);
    chk("t2_rx_b", rx_data, 8'h3D);
    wait_idle(dt);
    // 3: wrap, single-cycle done
    send(8'h00);
    wait_done(dt);
    chk("t3_rx_wrap", rx_data, 8'h00);
    @(negedge clk);
    chk("t3_done_one_cycle", done, 1'b0);
    chk("t3_rx_hold", rx_data, 8'h00);
    wait_idle(dt);
    // 4: start during busy is ignored
    d0 = dcnt;
    send(8'h11);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dt);
    chk("t4_done_time", dt, 64);
    chk("t4_rx", rx_data, 8'h01);
    wait_idle(dt);
    chk("t4_busy_width", dt, 68);
    repeat (5) @(negedge clk);
    chk("t4_one_frame", dcnt - d0, 1);
    chk("t4_still_idle", {busy, start_o}, 2'b00);
    // held start: back-to-back frames with a 4-cycle gap
    tx = 8'h22;
    start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    wait_done(dt);
    chk("t4_b2b_rx_a", rx_data, 8'h12);
    n = 0;
    while (!start_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("t4_gap_len", n, 4);
    e0 = cyc;
    start = 1'b0;
    chk("t4_b2b_busy", busy, 1'b1);
    wait_done(dt);
    chk("t4_b2b_done_time", dt, 64);
    chk("t4_b2b_rx_b", rx_data, 8'h23);
    wait_idle(dt);
    // 5: async reset mid-frame
    send(8'h77);
    repeat (33) @(negedge clk);
    d0 = dcnt;
    #1 rst = 1'b1;
    #1 chk("t5_reset_now", {rx_data, busy, done, start_o, sclk, mosi}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    chk("t5_no_done", dcnt - d0, 0);
    chk("t5_idle", {rx_data, busy}, 0);
    send(8'hC3);
    wait_done(dt);
    chk("t5_done_time", dt, 64);
    chk("t5_rx", rx_data, 8'h01);
    wait_idle(dt);
    chk("t5_slave_rx", s_last, 8'hC3);
    chk("t5_sclk_rises", s_rises, 8);
`ifdef SPI_MASTER_LOOPBACK_EN
    lb = 1'b1;
    send(8'h5A);
    wait_done(dt);
    chk("t6_loopback_rx", rx_data, 8'h5A);
    wait_idle(dt);
    lb = 1'b0;
`endif
    chk("mosi_stable_while_high", mosi_err, 1'b0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
